// File: rtl/stream_downsize.sv
// stream_downsize: wide-to-narrow stream converter.
// Takes T_DATA_RATIO-lane words with a per-lane keep mask and replays the
// emittable lanes, lane 0 first, as single T_DATA_WIDTH beats.
// Optional build macro STREAM_DOWNSIZE_SPARSE_EN: when defined, any keep
// pattern is honoured; when undefined, keep is treated as a contiguous prefix
// from lane 0 and emission stops at the first cleared keep bit.
// Note: rst_n is an active-high synchronous reset despite its name.
module stream_downsize #(
    parameter int T_DATA_WIDTH = 4,
    parameter int T_DATA_RATIO = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO],
    input  logic [T_DATA_RATIO-1:0] s_keep_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i
);

    localparam int IDX_W = $clog2(T_DATA_RATIO);

    typedef enum logic {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [T_DATA_WIDTH-1:0] hold_data_q [T_DATA_RATIO];
    logic [T_DATA_WIDTH-1:0] hold_data_d [T_DATA_RATIO];
    logic [T_DATA_RATIO-1:0] hold_mask_q, hold_mask_d;
    logic                    hold_last_q, hold_last_d;
    logic [T_DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                    m_last_q, m_last_d;
    logic                    m_valid_q, m_valid_d;

    // Set of lanes of the incoming word that will actually be emitted.
    logic [T_DATA_RATIO-1:0] in_mask;

`ifdef STREAM_DOWNSIZE_SPARSE_EN
    assign in_mask = s_keep_i;
`else
    // A lane counts only if it and every lane below it are kept.
    for (genvar gi = 0; gi < T_DATA_RATIO; gi++) begin : g_prefix
        assign in_mask[gi] = &s_keep_i[gi:0];
    end
`endif

    // Lowest set lane at or above 'start'; MSB of the result flags "found".
    function automatic logic [IDX_W:0] find_lane(input logic [T_DATA_RATIO-1:0] mask,
                                                 input int start);
        logic [IDX_W:0] res;
        res = '0;
        for (int i = T_DATA_RATIO - 1; i >= 0; i--) begin
            if (i >= start && mask[i]) begin
                res = {1'b1, IDX_W'(i)};
            end
        end
        return res;
    endfunction

    logic [IDX_W:0] first_lane, first_after, next_lane, next_after;
    logic           s_ready;
    logic           take_word;

    // Next-state, lane stepping and word capture.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hold_data_d = hold_data_q;
        hold_mask_d = hold_mask_q;
        hold_last_d = hold_last_q;
        m_data_d    = m_data_q;
        m_last_d    = m_last_q;
        m_valid_d   = m_valid_q;
        s_ready     = 1'b0;
        take_word   = 1'b0;

        first_lane  = find_lane(in_mask, 0);
        first_after = find_lane(in_mask, int'(first_lane[IDX_W-1:0]) + 1);
        next_lane   = find_lane(hold_mask_q, int'(idx_q) + 1);
        next_after  = find_lane(hold_mask_q, int'(next_lane[IDX_W-1:0]) + 1);

        case (state_q)
            EMPTY: begin
                s_ready   = 1'b1;
                take_word = s_valid_i;
            end
            SEND: begin
                if (m_ready_i) begin
                    if (next_lane[IDX_W]) begin
                        idx_d    = next_lane[IDX_W-1:0];
                        m_data_d = hold_data_q[next_lane[IDX_W-1:0]];
                        m_last_d = hold_last_q && !next_after[IDX_W];
                    end else begin
                        // Final beat leaves now: a new word may enter this same cycle.
                        s_ready   = 1'b1;
                        take_word = s_valid_i;
                        state_d   = EMPTY;
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase

        // Words with nothing to emit are consumed and dropped.
        if (take_word && first_lane[IDX_W]) begin
            hold_data_d = s_data_i;
            hold_mask_d = in_mask;
            hold_last_d = s_last_i;
            idx_d       = first_lane[IDX_W-1:0];
            m_data_d    = s_data_i[first_lane[IDX_W-1:0]];
            m_last_d    = s_last_i && !first_after[IDX_W];
            m_valid_d   = 1'b1;
            state_d     = SEND;
        end

        if (rst_n) begin
            s_ready = 1'b0;
        end
    end

    // State, hold register and registered output stage.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= EMPTY;
            idx_q       <= '0;
            hold_mask_q <= '0;
            hold_last_q <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            m_valid_q   <= 1'b0;
            for (int i = 0; i < T_DATA_RATIO; i++) begin
                hold_data_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hold_mask_q <= hold_mask_d;
            hold_last_q <= hold_last_d;
            m_data_q    <= m_data_d;
            m_last_q    <= m_last_d;
            m_valid_q   <= m_valid_d;
            hold_data_q <= hold_data_d;
        end
    end

    assign s_ready_o = s_ready;
    assign m_data_o  = m_data_q;
    assign m_last_o  = m_last_q;
    assign m_valid_o = m_valid_q;

endmodule

// File: tb/tb_stream_downsize.sv
// Directed testbench for stream_downsize (W=4, RATIO=2).
module tb_stream_downsize;

    logic       clk;
    logic       rst_n;
    logic [3:0] s_data [2];
    logic [1:0] s_keep;
    logic       s_last;
    logic       s_valid;
    logic       s_ready;
    logic [3:0] m_data;
    logic       m_last;
    logic       m_valid;
    logic       m_ready;

    int n_compared;
    int n_mismatched;

    stream_downsize #(
        .T_DATA_WIDTH(4),
        .T_DATA_RATIO(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_data_i (s_data),
        .s_keep_i (s_keep),
        .s_last_i (s_last),
        .s_valid_i(s_valid),
        .s_ready_o(s_ready),
        .m_data_o (m_data),
        .m_last_o (m_last),
        .m_valid_o(m_valid),
        .m_ready_i(m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one clock; land 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] d0, input logic [3:0] d1, input logic [1:0] keep,
                         input logic last, input logic valid);
        s_data[0] = d0;
        s_data[1] = d1;
        s_keep    = keep;
        s_last    = last;
        s_valid   = valid;
    endtask

    task automatic idle_in();
        drive(4'h0, 4'h0, 2'b00, 1'b0, 1'b0);
    endtask

    // Check the presented beat; data/last are only meaningful while valid.
    task automatic expect_beat(input string tag, input logic valid, input logic [3:0] data,
                               input logic last);
        check_val({tag, ".valid"}, 32'(m_valid), 32'(valid));
        if (valid) begin
            check_val({tag, ".data"}, 32'(m_data), 32'(data));
            check_val({tag, ".last"}, 32'(m_last), 32'(last));
        end
    endtask

    task automatic expect_ready(input string tag, input logic exp);
        #1;
        check_val({tag, ".s_ready"}, 32'(s_ready), 32'(exp));
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst_n   = 1'b1;
        m_ready = 1'b1;
        idle_in();

        // Reset state
        step();
        step();
        check_val("rst.m_valid", 32'(m_valid), 32'd0);
        check_val("rst.m_last", 32'(m_last), 32'd0);
        check_val("rst.m_data", 32'(m_data), 32'd0);
        check_val("rst.s_ready", 32'(s_ready), 32'd0);
        rst_n = 1'b0;
        expect_ready("rel", 1'b1);

        // 1. Full word {3,7}, no last
        drive(4'h3, 4'h7, 2'b11, 1'b0, 1'b1);
        expect_ready("t1.acc", 1'b1);
        step();
        idle_in();
        expect_beat("t1.b0", 1'b1, 4'h3, 1'b0);
        expect_ready("t1.b0", 1'b0);
        step();
        expect_beat("t1.b1", 1'b1, 4'h7, 1'b0);
        expect_ready("t1.b1", 1'b1);
        step();
        expect_beat("t1.end", 1'b0, 4'h0, 1'b0);

        // 2. Packet end {A,5} last, then partial {C} keep=01 last
        drive(4'hA, 4'h5, 2'b11, 1'b1, 1'b1);
        step();
        idle_in();
        expect_beat("t2.b0", 1'b1, 4'hA, 1'b0);
        step();
        expect_beat("t2.b1", 1'b1, 4'h5, 1'b1);
        step();
        expect_beat("t2.gap", 1'b0, 4'h0, 1'b0);
        drive(4'hC, 4'hD, 2'b01, 1'b1, 1'b1);
        step();
        idle_in();
        expect_beat("t2.part", 1'b1, 4'hC, 1'b1);
        expect_ready("t2.part", 1'b1);
        step();
        expect_beat("t2.pend", 1'b0, 4'h0, 1'b0);

        // 3. Backpressure on beat 3 for 3 cycles
        drive(4'h3, 4'h7, 2'b11, 1'b0, 1'b1);
        step();
        idle_in();
        m_ready = 1'b0;
        expect_beat("t3.b0", 1'b1, 4'h3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_beat($sformatf("t3.hold%0d", i), 1'b1, 4'h3, 1'b0);
            expect_ready($sformatf("t3.hold%0d", i), 1'b0);
        end
        m_ready = 1'b1;
        step();
        expect_beat("t3.b1", 1'b1, 4'h7, 1'b0);
        step();
        expect_beat("t3.end", 1'b0, 4'h0, 1'b0);

        // 4. Streaming {1,2},{3,4},{5,6}(last): six beats back to back
        drive(4'h1, 4'h2, 2'b11, 1'b0, 1'b1);
        step();
        drive(4'h3, 4'h4, 2'b11, 1'b0, 1'b1);
        expect_beat("t4.b1", 1'b1, 4'h1, 1'b0);
        expect_ready("t4.b1", 1'b0);
        step();
        expect_beat("t4.b2", 1'b1, 4'h2, 1'b0);
        expect_ready("t4.b2", 1'b1);
        step();
        drive(4'h5, 4'h6, 2'b11, 1'b1, 1'b1);
        expect_beat("t4.b3", 1'b1, 4'h3, 1'b0);
        step();
        expect_beat("t4.b4", 1'b1, 4'h4, 1'b0);
        expect_ready("t4.b4", 1'b1);
        step();
        idle_in();
        expect_beat("t4.b5", 1'b1, 4'h5, 1'b0);
        step();
        expect_beat("t4.b6", 1'b1, 4'h6, 1'b1);
        step();
        expect_beat("t4.end", 1'b0, 4'h0, 1'b0);

        // 5. Reset while beat 3 of {3,7} is presented
        drive(4'h3, 4'h7, 2'b11, 1'b0, 1'b1);
        step();
        idle_in();
        expect_beat("t5.b0", 1'b1, 4'h3, 1'b0);
        rst_n = 1'b1;
        step();
        check_val("t5.rst.m_valid", 32'(m_valid), 32'd0);
        check_val("t5.rst.s_ready", 32'(s_ready), 32'd0);
        rst_n = 1'b0;
        expect_ready("t5.rel", 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_beat($sformatf("t5.quiet%0d", i), 1'b0, 4'h0, 1'b0);
        end

        // 6. keep=10, {9,E}, last
        drive(4'h9, 4'hE, 2'b10, 1'b1, 1'b1);
        expect_ready("t6.acc", 1'b1);
        step();
        idle_in();
`ifdef STREAM_DOWNSIZE_SPARSE_EN
        expect_beat("t6.sparse", 1'b1, 4'hE, 1'b1);
        step();
        expect_beat("t6.end", 1'b0, 4'h0, 1'b0);
`else
        expect_beat("t6.drop", 1'b0, 4'h0, 1'b0);
`endif
        drive(4'h2, 4'hB, 2'b11, 1'b0, 1'b1);
        expect_ready("t6.next", 1'b1);
        step();
        idle_in();
        expect_beat("t6.n0", 1'b1, 4'h2, 1'b0);
        step();
        expect_beat("t6.n1", 1'b1, 4'hB, 1'b0);
        step();
        expect_beat("t6.end2", 1'b0, 4'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
